// File: rtl/interrupt_trap_arbiter_pkg.sv
// Shared types and constants for the interrupt/trap arbiter.
package int_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    TRAP = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_P = 2'd0,
    SRC_S = 2'd1,
    SRC_T = 2'd2
  } src_id_e;

  localparam logic [31:0] MCAUSE_INT_BIT = 32'h8000_0000;

  localparam int unsigned DEF_CAUSE_MSI    = 3;
  localparam int unsigned DEF_CAUSE_MTI    = 7;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  // Builds an interrupt mcause value: interrupt bit set, code in [30:0].
  function automatic logic [31:0] make_mcause(input logic [30:0] code);
    return MCAUSE_INT_BIT | {1'b0, code};
  endfunction

endpackage

// File: rtl/interrupt_trap_arbiter_if.sv
// Trap-request bundle between the interrupt sources/CSR unit and the arbiter.
// The arbiter uses the slave modport; the CSR/trap side uses master.
interface interrupt_trap_arbiter_if;
  logic        mie;
  logic        msie;
  logic        mtie;
  logic        sw_int;
  logic        timer_int;
  logic        p_int;
  logic [31:0] p_mcause;
  logic        csr_busy;
  logic        trap_taken;
  logic        mret;
  logic        int_req;
  logic [31:0] int_mcause;
  logic        p_int_read;
  logic        in_trap;

  modport slave (
    input  mie, msie, mtie, sw_int, timer_int, p_int, p_mcause,
           csr_busy, trap_taken, mret,
    output int_req, int_mcause, p_int_read, in_trap
  );

  modport master (
    output mie, msie, mtie, sw_int, timer_int, p_int, p_mcause,
           csr_busy, trap_taken, mret,
    input  int_req, int_mcause, p_int_read, in_trap
  );
endinterface

// File: rtl/interrupt_trap_arbiter_starve_ctr.sv
// Saturating count of consecutive peripheral traps taken while the timer
// was eligible; force_timer makes the next arbitration favour the timer.
// Only instantiated when INT_ARB_STARVE_GUARD_EN is defined.
module int_arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic take_p,
  input  logic take_t,
  input  logic t_elig,
  output logic force_timer
);

  localparam int unsigned W = $clog2(STARVE_LIMIT + 1);

  logic [W-1:0] cnt_q;

  // Count P traps taken with T waiting; clear on T service or P with T idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (take_t || (take_p && !t_elig)) begin
      cnt_q <= '0;
    end else if (take_p && t_elig && (cnt_q != W'(STARVE_LIMIT))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign force_timer = (cnt_q == W'(STARVE_LIMIT));

endmodule

// File: rtl/interrupt_trap_arbiter.sv
// Merges peripheral, machine-software and machine-timer interrupts into a
// single trap request with fixed priority P > S > T and a busy/ack handshake.
// Optional starvation guard for the timer: define INT_ARB_STARVE_GUARD_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no request; arbitrate when mie & ~csr_busy & any source
// REQ   | int_req high, winner and mcause latched until ack or abort
// TRAP  | handler running (in_trap); wait for mret
import int_arb_pkg::*;

module interrupt_trap_arbiter #(
  parameter int unsigned CAUSE_MSI    = DEF_CAUSE_MSI,
  parameter int unsigned CAUSE_MTI    = DEF_CAUSE_MTI,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input logic                    clk,
  input logic                    reset,
  interrupt_trap_arbiter_if.slave bus
);

  arb_state_e  state_q, state_d;
  src_id_e     win_q, win_d;
  logic [31:0] cause_q, cause_d;
  logic        p_read_q, p_read_d;

  logic        el_p, el_s, el_t, any_el;
  logic        force_timer;
  src_id_e     pick_src;
  logic [31:0] pick_cause;

  assign el_p   = bus.p_int;
  assign el_s   = bus.sw_int & bus.msie;
  assign el_t   = bus.timer_int & bus.mtie;
  assign any_el = el_p | el_s | el_t;

`ifdef INT_ARB_STARVE_GUARD_EN
  logic take_p, take_t;

  assign take_p = (state_q == REQ) && bus.trap_taken && (win_q == SRC_P);
  assign take_t = (state_q == REQ) && bus.trap_taken && (win_q == SRC_T);

  int_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk         (clk),
    .reset       (reset),
    .take_p      (take_p),
    .take_t      (take_t),
    .t_elig      (el_t),
    .force_timer (force_timer)
  );
`else
  assign force_timer = 1'b0;
`endif

  // Fixed-priority pick; p_mcause only reaches the cause when p_int is set.
  always_comb begin
    pick_src   = SRC_T;
    pick_cause = make_mcause(31'(CAUSE_MTI));
    if (force_timer && el_t) begin
      pick_src   = SRC_T;
      pick_cause = make_mcause(31'(CAUSE_MTI));
    end else if (el_p) begin
      pick_src   = SRC_P;
      pick_cause = make_mcause(bus.p_mcause[30:0]);
    end else if (el_s) begin
      pick_src   = SRC_S;
      pick_cause = make_mcause(31'(CAUSE_MSI));
    end
  end

  // Next-state logic; trap_taken in REQ takes precedence over an abort.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cause_d  = cause_q;
    p_read_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mie && !bus.csr_busy && any_el) begin
          state_d = REQ;
          win_d   = pick_src;
          cause_d = pick_cause;
        end
      end
      REQ: begin
        if (bus.trap_taken) begin
          state_d  = TRAP;
          p_read_d = (win_q == SRC_P);
        end else if (bus.csr_busy || !bus.mie) begin
          state_d = IDLE;
        end
      end
      TRAP: begin
        if (bus.mret) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      win_q    <= SRC_P;
      cause_q  <= '0;
      p_read_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      cause_q  <= cause_d;
      p_read_q <= p_read_d;
    end
  end

  assign bus.int_req    = (state_q == REQ);
  assign bus.int_mcause = cause_q;
  assign bus.p_int_read = p_read_q;
  assign bus.in_trap    = (state_q == TRAP);

endmodule

// File: tb/tb_interrupt_trap_arbiter.sv
// Self-checking bench for interrupt_trap_arbiter: expected mcause values are
// queued as stimulus is set up and popped when int_req appears.
module tb_interrupt_trap_arbiter;

  logic clk = 1'b0;
  logic reset;

  interrupt_trap_arbiter_if bus ();

  interrupt_trap_arbiter #(
    .CAUSE_MSI    (3),
    .CAUSE_MTI    (7),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) if (bus.p_int_read) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for int_req, then pop and compare the expected mcause.
  task automatic wait_req(input string tag, output int cyc);
    logic [31:0] e;
    cyc = 0;
    while (!bus.int_req && cyc < 50) begin
      tick();
      cyc++;
    end
    check({tag, "_seen"}, 32'(bus.int_req), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_mcause"}, bus.int_mcause, e);
    end
  endtask

  task automatic pulse_mret();
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
  endtask

  int cyc;
  int p0;
  logic saw_req;

  initial begin
    bus.mie = 0; bus.msie = 0; bus.mtie = 0; bus.sw_int = 0; bus.timer_int = 0;
    bus.p_int = 0; bus.p_mcause = 0; bus.csr_busy = 0; bus.trap_taken = 0; bus.mret = 0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_req",    32'(bus.int_req), 0);
    check("rst_trap",   32'(bus.in_trap), 0);
    check("rst_pread",  32'(bus.p_int_read), 0);
    check("rst_mcause", bus.int_mcause, 0);

    // P beats S; pop on take; S follows two cycles after mret.
    bus.mie = 1; bus.p_int = 1; bus.p_mcause = 32'd13; bus.sw_int = 1; bus.msie = 1;
    exp_q.push_back(32'h8000_000D);
    wait_req("t1_p", cyc);
    check("t1_p_lat", cyc, 1);
    bus.trap_taken = 1;
    tick();
    bus.trap_taken = 0;
    bus.p_int = 0;
    check("t1_pread",   32'(bus.p_int_read), 1);
    check("t1_in_trap", 32'(bus.in_trap), 1);
    check("t1_req_lo",  32'(bus.int_req), 0);
    tick();
    check("t1_pread_1cy", 32'(bus.p_int_read), 0);
    bus.trap_taken = 1;
    tick();
    bus.trap_taken = 0;
    tick();
    check("t1_trap_hold", 32'(bus.in_trap), 1);
    check("t1_pulses", pulses, 1);
    exp_q.push_back(32'h8000_0003);
    pulse_mret();
    check("t1_mret_trap", 32'(bus.in_trap), 0);
    check("t1_mret_req",  32'(bus.int_req), 0);
    wait_req("t1_s", cyc);
    check("t1_s_lat", cyc, 1);
    bus.trap_taken = 1;
    tick();
    bus.trap_taken = 0;
    bus.sw_int = 0;
    check("t1_s_nopop", 32'(bus.p_int_read), 0);
    check("t1_s_trap",  32'(bus.in_trap), 1);
    pulse_mret();

    // Timer request aborted by csr_busy, re-issued when busy clears.
    bus.mtie = 1; bus.timer_int = 1;
    exp_q.push_back(32'h8000_0007);
    wait_req("t2_t", cyc);
    bus.csr_busy = 1;
    tick();
    check("t2_abort_req", 32'(bus.int_req), 0);
    check("t2_abort_pop", 32'(bus.p_int_read), 0);
    tick(); tick();
    check("t2_busy_hold", 32'(bus.int_req), 0);
    exp_q.push_back(32'h8000_0007);
    bus.csr_busy = 0;
    wait_req("t2_retry", cyc);
    check("t2_retry_lat", cyc, 1);
    bus.trap_taken = 1;
    tick();
    bus.trap_taken = 0;
    bus.timer_int = 0;
    check("t2_nopop", 32'(bus.p_int_read), 0);
    pulse_mret();

    // trap_taken and csr_busy together on a P grant: trap wins, one pop.
    bus.p_int = 1; bus.p_mcause = 32'd20;
    exp_q.push_back(32'h8000_0014);
    wait_req("t3_p", cyc);
    p0 = pulses;
    bus.trap_taken = 1; bus.csr_busy = 1;
    tick();
    bus.trap_taken = 0; bus.csr_busy = 0; bus.p_int = 0;
    check("t3_trap",  32'(bus.in_trap), 1);
    check("t3_pread", 32'(bus.p_int_read), 1);
    tick(); tick(); tick();
    check("t3_one_pop", pulses - p0, 1);
    pulse_mret();

    // mie=0 masks everything; raising it requests with one-cycle latency.
    bus.mie = 0; bus.p_int = 1; bus.p_mcause = 32'd12; bus.sw_int = 1; bus.timer_int = 1;
    saw_req = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.int_req) saw_req = 1;
    end
    check("t4_masked", 32'(saw_req), 0);
    exp_q.push_back(32'h8000_000C);
    bus.mie = 1;
    wait_req("t4_unmask", cyc);
    check("t4_lat", cyc, 1);

    // Reset while in REQ with P winner: silent abort.
    p0 = pulses;
    reset = 1;
    bus.trap_taken = 1;
    tick();
    bus.trap_taken = 0;
    bus.mie = 0; bus.p_int = 0; bus.sw_int = 0; bus.timer_int = 0;
    check("t5_req",    32'(bus.int_req), 0);
    check("t5_trap",   32'(bus.in_trap), 0);
    check("t5_pread",  32'(bus.p_int_read), 0);
    check("t5_mcause", bus.int_mcause, 0);
    reset = 0;
    tick(); tick();
    check("t5_no_pop", pulses - p0, 0);

    // Peripheral flood with timer pending.
    bus.mie = 1; bus.mtie = 1; bus.timer_int = 1; bus.msie = 0;
    bus.p_int = 1; bus.p_mcause = 32'd15;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h8000_000F);
      wait_req($sformatf("t6_p%0d", i), cyc);
      bus.trap_taken = 1;
      tick();
      bus.trap_taken = 0;
      pulse_mret();
    end
`ifdef INT_ARB_STARVE_GUARD_EN
    exp_q.push_back(32'h8000_0007);
`else
    exp_q.push_back(32'h8000_000F);
`endif
    wait_req("t6_fifth", cyc);
    bus.trap_taken = 1;
    tick();
    bus.trap_taken = 0;
    pulse_mret();
    bus.p_int = 0; bus.timer_int = 0;
    tick();
    check("t6_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_trap_arbiter.md
Name: interrupt_trap_arbiter

Overview:
Merges the three machine-level interrupt sources into one trap request toward the CSR/trap unit. The sources are the peripheral interrupt queue output (p_int/p_mcause), machine software and machine timer. The block applies global/local enables, fixed priority and a busy/acknowledge handshake. It is the only consumer of the peripheral queue, issuing p_int_read exactly once per peripheral trap actually taken. It tracks in-trap status so no new request is raised until mret.

Parameters:
CAUSE_MSI, 3, exception code for machine software interrupt
CAUSE_MTI, 7, exception code for machine timer interrupt
STARVE_LIMIT, 4, consecutive peripheral grants allowed while timer pending (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mie  in  1  mstatus.MIE global enable
msie  in  1  mie.MSIE local enable
mtie  in  1  mie.MTIE local enable
sw_int  in  1  software interrupt, level
timer_int  in  1  timer interrupt (mtime>=mtimecmp), level
p_int  in  1  peripheral queue has head entry
p_mcause  in  32  peripheral head cause code (12 and up)
csr_busy  in  1  CSR unit cannot accept trap this cycle
trap_taken  in  1  one-cycle pulse: CSR unit committed the trap
mret  in  1  one-cycle pulse: handler returned
int_req  out  1  trap request to CSR unit
int_mcause  out  32  mcause value for int_req, bit 31 = 1
p_int_read  out  1  one-cycle pop pulse to peripheral queue
in_trap  out  1  handler active

Behaviour:
- Reset (sync, active-high): state IDLE; int_req=0, int_mcause=0, p_int_read=0, in_trap=0; starve counter=0. Reset mid-REQ or mid-TRAP aborts silently. No p_int_read is emitted.
- Eligible sources: P = p_int; S = sw_int&msie; T = timer_int&mtie. Arbitration only if mie=1.
- Priority is fixed: P > S > T.
- FSM states:
  - IDLE: if mie & ~csr_busy & (P|S|T), latch the winner id and int_mcause, then go to REQ. int_req=1 from the next cycle (1-cycle latency).
  - For P: int_mcause = {1'b1, p_mcause[30:0]}. For S: 0x80000003. For T: 0x80000007.
  - REQ: int_req held, int_mcause stable.
    - trap_taken -> TRAP, int_req=0, in_trap=1. If the winner is P, p_int_read=1 for exactly the next cycle.
    - else csr_busy, or mie falls -> IDLE, int_req=0, no pop; re-arbitrates later.
    - trap_taken and csr_busy in the same cycle: trap_taken wins.
  - TRAP: in_trap=1, no arbitration. mret -> IDLE with in_trap=0 next cycle. The earliest next int_req is 2 cycles after mret.
    - trap_taken while in TRAP is ignored. mret in IDLE/REQ is ignored.
- Winner source dropping while in REQ (e.g. software clears sw_int): the request is held regardless. The CSR unit owns the outcome.
- P is re-sampled only in IDLE; p_mcause is never sampled while p_int=0.
- At most one p_int_read per trap_taken. It is never issued without a prior P grant.

Optional Feature:
Macro INT_ARB_STARVE_GUARD_EN.
- With the macro: a counter (width $clog2(STARVE_LIMIT+1)) counts consecutive P grants taken while T is eligible. When it equals STARVE_LIMIT, the next arbitration grants T ahead of P and S.
- The counter clears on any T grant, or on a P grant with T ineligible. It saturates and never wraps.
- Without the macro: strict P > S > T; no counter logic.

Decomposition:
- Package int_arb_pkg:
  - state enum {IDLE, REQ, TRAP}
  - source id enum {SRC_P, SRC_S, SRC_T}
  - MCAUSE_INT_BIT constant
  - default cause constants
- One sub-module is natural: int_arb_starve_ctr. It holds the saturating counter and emits force_timer, and is instantiated only under INT_ARB_STARVE_GUARD_EN.

Test Plan:
- mie=1, p_int=1, p_mcause=13, sw_int=1, msie=1 in IDLE -> int_req next cycle, int_mcause=0x8000000D. trap_taken -> p_int_read 1-cycle pulse, in_trap=1. mret -> in_trap=0; SW request 0x80000003 appears 2 cycles after mret.
- In REQ for timer, assert csr_busy without trap_taken -> int_req drops next cycle, no p_int_read, re-request once csr_busy=0.
- trap_taken and csr_busy in the same cycle with a P grant -> TRAP entered, exactly one p_int_read.
- mie=0 with all sources active -> int_req stays 0 for 20 cycles. Raise mie -> request with 1-cycle latency.
- reset asserted in REQ (P winner) -> all outputs 0 next cycle, p_int_read never pulses.
- With INT_ARB_STARVE_GUARD_EN, STARVE_LIMIT=4: p_int and timer_int held, 4 P traps completed -> 5th grant int_mcause=0x80000007. Without the macro, the 5th grant is P.
